// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared constants, capture state type and decimation clamp
package wavegen_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int MAX_DECIM_LOG2 = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } cap_state_t;

    function automatic logic [3:0] clamp_decim(input logic [3:0] d);
        return (d > 4'(MAX_DECIM_LOG2)) ? 4'(MAX_DECIM_LOG2) : d;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port RAM, one write port, one registered read port
module capture_ram #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sample_capture_buffer.sv
// rtl/sample_capture_buffer.sv - decimating burst capture and host drain buffer
// Define CAPTURE_AVG_EN for boxcar-mean decimation instead of drop decimation.
module sample_capture_buffer
    import wavegen_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int SAMPLE_W = wavegen_pkg::SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       arm,
    input  logic [3:0]                 decim_log2,
    input  logic                       rd_en,
    output logic signed [SAMPLE_W-1:0] rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    output logic                       done,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = MAX_DECIM_LOG2;

    localparam logic [LW-1:0] LVL_LAST = LW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    cap_state_t        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        dlog_q, dlog_d;
    logic              done_q, done_d;
    logic              underflow_q, underflow_d;
    logic              drained_q, drained_d;

    logic [CW:0]       one_sh;
    logic [CW-1:0]     cnt_mask;
    logic              group_end;
    logic              ram_we;
    logic signed [SAMPLE_W-1:0] wr_data;
    logic [SAMPLE_W-1:0]        ram_rdata;

    assign one_sh    = (CW + 1)'(1) << dlog_q;
    assign cnt_mask  = CW'(one_sh - 1'b1);
    assign group_end = (state_q == CAPTURE) && (cnt_q == cnt_mask);
    assign ram_we    = group_end && !arm;

`ifdef CAPTURE_AVG_EN
    localparam int ACC_W = SAMPLE_W + MAX_DECIM_LOG2;

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_mean;

    // Counter value 0 opens a new group, so the stale sum is dropped there.
    always_comb begin
        acc_base = (cnt_q == '0) ? ACC_W'(0) : acc_q;
        acc_d    = acc_base + ACC_W'(sample_in);
        acc_mean = acc_d >>> dlog_q;
        wr_data  = acc_mean[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (state_q == CAPTURE) begin
            acc_q <= acc_d;
        end
    end
`else
    assign wr_data = sample_in;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        dlog_d      = dlog_q;
        done_d      = 1'b0;
        underflow_d = underflow_q;
        drained_d   = drained_q;

        if (arm) begin
            // Arm restarts from any state; an aborted burst never pulses done.
            state_d     = CAPTURE;
            dlog_d      = clamp_decim(decim_log2);
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            cnt_d       = '0;
            underflow_d = 1'b0;
            drained_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd_en && drained_q && (level_q == '0)) begin
                        underflow_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    cnt_d = group_end ? '0 : cnt_q + 1'b1;
                    if (group_end) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        level_d  = level_q + 1'b1;
                        if (level_q == LVL_LAST) begin
                            state_d = DRAIN;
                            done_d  = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en && (level_q != '0)) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        level_d  = level_q - 1'b1;
                        if (level_q == LVL_ONE) begin
                            state_d   = IDLE;
                            drained_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            dlog_q      <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            drained_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            dlog_q      <= dlog_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
            drained_q   <= drained_d;
        end
    end

    // Reading at the next pointer keeps the registered RAM output aligned
    // with rd_ptr_q, giving fall-through words at full read rate.
    capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    assign rd_data   = (state_q == DRAIN) ? $signed(ram_rdata) : '0;
    assign level     = level_q;
    assign busy      = (state_q == CAPTURE);
    assign done      = done_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sample_capture_buffer.sv
// tb/tb_sample_capture_buffer.sv - randomized self-checking bench for sample_capture_buffer
module tb_sample_capture_buffer;

    localparam int DEPTH = 16;
    localparam int SW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic signed [SW-1:0] sample_in;
    logic                 arm;
    logic [3:0]           decim_log2;
    logic                 rd_en;
    logic signed [SW-1:0] rd_data;
    logic [LW-1:0]        level;
    logic                 busy;
    logic                 done;
    logic                 underflow;

    int checks = 0;
    int errors = 0;
    int cur_d  = 0;
    int sq[$];
    int exp_q[$];

    always #5 clk = ~clk;

    sample_capture_buffer #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (SW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_in  (sample_in),
        .arm        (arm),
        .decim_log2 (decim_log2),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .level      (level),
        .busy       (busy),
        .done       (done),
        .underflow  (underflow)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_sample();
        logic signed [SW-1:0] r;
        r = SW'($urandom);
        return int'(r);
    endfunction

    task automatic arm_burst(input int dl);
        arm        = 1'b1;
        decim_log2 = 4'(dl);
        sample_in  = SW'(rand_sample());
        tick();
        arm   = 1'b0;
        cur_d = (dl > 10) ? 10 : dl;
        sq.delete();
    endtask

    // mode 0: ramp from 0, mode 1: constant cval, mode 2: random with stray rd_en
    task automatic capture(input int mode, input int cval);
        int g, n, first, pulses, v;
        g      = 1 << cur_d;
        n      = DEPTH * g;
        first  = -1;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            v         = (mode == 0) ? i : (mode == 1) ? cval : rand_sample();
            sample_in = SW'(v);
            rd_en     = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            sq.push_back(v);
            tick();
            if (done) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        rd_en = 1'b0;
        check_eq("done_at", first, n - 1);
        check_eq("done_cnt", pulses, 1);
        check_eq("busy_drain", busy, 0);
        check_eq("level_full", level, DEPTH);
    endtask

    function automatic void build_expected();
        int g, sum, q;
        g = 1 << cur_d;
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
`ifdef CAPTURE_AVG_EN
            sum = 0;
            for (int j = 0; j < g; j++) sum += sq[k * g + j];
            q = sum / g;
            if ((sum % g) != 0 && sum < 0) q = q - 1;
            exp_q.push_back(q);
`else
            sum = 0;
            q   = sq[k * g + g - 1];
            exp_q.push_back(q + sum);
`endif
        end
    endfunction

    task automatic drain(input int nread);
        tick();
        check_eq("done_pulse", done, 0);
        for (int k = 0; k < nread; k++) begin
            check_eq("rd_data", rd_data, exp_q[k]);
            check_eq("level_rd", level, DEPTH - k);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check_eq("level_end", level, DEPTH - nread);
        if (nread == DEPTH) begin
            check_eq("busy_idle", busy, 0);
            check_eq("rd_data_idle", rd_data, 0);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        arm        = 1'b0;
        rd_en      = 1'b0;
        sample_in  = '0;
        decim_log2 = '0;
        repeat (3) tick();
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_underflow", underflow, 0);
        reset_n = 1'b1;
        tick();

        // rd_en in IDLE after reset (no drain yet) is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq("idle_rd_ignored", underflow, 0);

        arm_burst(0);
        check_eq("busy_cap", busy, 1);
        capture(0, 0);
        build_expected();
        drain(DEPTH);

        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq("underflow_set", underflow, 1);
        check_eq("underflow_level", level, 0);
        repeat (3) tick();
        check_eq("underflow_sticky", underflow, 1);

        arm_burst(2);
        check_eq("underflow_clr", underflow, 0);
        capture(0, 0);
        build_expected();
        drain(DEPTH);

        arm_burst(1);
        capture(1, -3);
        build_expected();
        drain(DEPTH);

        arm_burst(10);
        capture(1, -32768);
        build_expected();
        drain(DEPTH);

        for (int r = 0; r < 3; r++) begin
            arm_burst(int'($urandom_range(0, 3)));
            capture(2, 0);
            build_expected();
            drain(DEPTH);
        end

        arm_burst(15);
        capture(2, 0);
        build_expected();
        drain(DEPTH);

        // abort after 5 writes
        arm_burst(0);
        begin
            int pulses = 0;
            for (int i = 0; i < 5; i++) begin
                sample_in = SW'(1000 + i);
                tick();
                if (done) pulses++;
            end
            check_eq("abort_level5", level, 5);
            arm_burst(0);
            if (done) pulses++;
            check_eq("abort_level0", level, 0);
            check_eq("abort_no_done", pulses, 0);
            check_eq("abort_busy", busy, 1);
        end
        capture(0, 0);
        build_expected();
        drain(DEPTH);

        // reset in the middle of a drain
        arm_burst(1);
        capture(2, 0);
        build_expected();
        drain(DEPTH - 7);
        check_eq("pre_rst_level", level, 7);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_rd_data", rd_data, 0);
        check_eq("mid_rst_level", level, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_underflow", underflow, 0);
        tick();
        reset_n = 1'b1;
        tick();
        arm_burst(0);
        capture(2, 0);
        build_expected();
        drain(DEPTH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
